// File: rtl/irq_pkg.sv
// Shared constants and types for the four-channel interrupt capture front end.
package irq_pkg;

    localparam int N_CH = 4;
    localparam int ID_W = 2;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } offer_state_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-stage flop synchroniser for a bus of independent asynchronous lines.
module irq_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    // Each stage takes the previous one; stage 0 takes the raw input.
    always_comb begin
        sync_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser chain registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/irq_capture_4.sv
// Four-channel interrupt front end: synchronise, capture edge/level requests
// into a pending register, present the masked vector to the priority encoder,
// and offer the highest-priority channel (index 0 first) over valid/ready.
module irq_capture_4
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] irq_in,
    input  logic [N_CH-1:0] irq_mode,
    input  logic [N_CH-1:0] irq_mask,
    input  logic [N_CH-1:0] pend_clr,
    output logic [N_CH-1:0] pending,
    output logic            irq_out,
    output logic            irq_valid,
    output logic [ID_W-1:0] irq_id,
    input  logic            irq_ready
);

    // Lowest set index wins, matching the downstream encoder's priority.
    function automatic logic [ID_W-1:0] lowest_index(input logic [N_CH-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    logic [N_CH-1:0] sync_s;
    logic [N_CH-1:0] set_s;
    logic [N_CH-1:0] clr_s;
    logic [N_CH-1:0] pending_s;
    logic            accept_s;

    logic [N_CH-1:0] prev_q,      prev_d;
    logic [N_CH-1:0] pend_q,      pend_d;
    offer_state_e    state_q,     state_d;
    logic            irq_valid_q, irq_valid_d;
    logic [ID_W-1:0] irq_id_q,    irq_id_d;

    irq_sync #(
        .WIDTH  (N_CH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (irq_in),
        .d_out (sync_s)
    );

    assign pending_s = pend_q & irq_mask;
    assign accept_s  = irq_valid_q & irq_ready;

    // Set/clear terms per channel; set is applied last so a coincident edge is never lost.
    always_comb begin
        set_s  = {N_CH{1'b0}};
        clr_s  = pend_clr;
        prev_d = sync_s;
        for (int i = 0; i < N_CH; i++) begin
            case (irq_mode[i])
                MODE_EDGE:  set_s[i] = sync_s[i] & ~prev_q[i];
                MODE_LEVEL: set_s[i] = sync_s[i];
                default:    set_s[i] = 1'b0;
            endcase
            if (accept_s && (irq_id_q == ID_W'(i))) begin
                clr_s[i] = 1'b1;
            end else begin
                clr_s[i] = pend_clr[i];
            end
        end
        pend_d = (pend_q & ~clr_s) | set_s;
    end

    // Offer FSM: latch the winner in IDLE, hold it unchanged until the consumer accepts.
    always_comb begin
        state_d     = state_q;
        irq_valid_d = irq_valid_q;
        irq_id_d    = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_s) begin
                    state_d     = ST_OFFER;
                    irq_valid_d = 1'b1;
                    irq_id_d    = lowest_index(pending_s);
                end else begin
                    state_d     = ST_IDLE;
                    irq_valid_d = 1'b0;
                end
            end
            ST_OFFER: begin
                if (irq_ready) begin
                    state_d     = ST_IDLE;
                    irq_valid_d = 1'b0;
                end else begin
                    state_d     = ST_OFFER;
                    irq_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                irq_valid_d = 1'b0;
            end
        endcase
    end

    // State, capture and offer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= {N_CH{1'b0}};
            pend_q      <= {N_CH{1'b0}};
            state_q     <= ST_IDLE;
            irq_valid_q <= 1'b0;
            irq_id_q    <= {ID_W{1'b0}};
        end else begin
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            state_q     <= state_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
        end
    end

    assign pending   = pending_s;
    assign irq_out   = |pending_s;
    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;

endmodule
